// File: rtl/mac_pkg.sv
// Shared defaults and FSM state encoding for the MAC matrix controller.
package mac_pkg;

  localparam int MAC_WIDTH_DEF = 8;
  localparam int DATA_SIZE_DEF = 8;
  localparam int LAT_DEF       = 2 * MAC_WIDTH_DEF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Width of a row index; never narrower than one bit.
  function automatic int row_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_valid_pipe.sv
// Valid-tag shift register: a tag entering on tag_in appears on tag_out
// exactly DEPTH cycles later.
module mac_valid_pipe
  import mac_pkg::*;
#(
  parameter int DEPTH = LAT_DEF + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift toward the MSB, new tag enters at bit 0.
  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = tag_in;
  end

  // Tag register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign tag_out = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_matrix_ctrl.sv
// Sequencer for a MAC_WIDTH x MAC_WIDTH mac_matrix: fetches weight rows,
// streams operand vectors, waits out the array latency and collects results.
// Optional build macro MAC_CTRL_PERF_EN adds perf_cycles / perf_stalls.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | one weight row per cycle, MAC_WIDTH cycles
// STREAM | accepting num_vectors operand transfers, bubbles allowed
// DRAIN  | LAT cycles for the last vector to reach the bottom edge
// DONE   | one-cycle completion pulse
module mac_matrix_ctrl
  import mac_pkg::*;
#(
  parameter int MAC_WIDTH = MAC_WIDTH_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int LAT       = 2 * MAC_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [15:0]                         num_vectors,
  output logic                                busy,
  output logic                                done,
  output logic                                w_rd_en,
  output logic [row_bits(MAC_WIDTH)-1:0]      w_rd_row,
  output logic                                instr,
  output logic [7:0]                          mac_matrix_counter,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0]      in_data1,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0]      in_data2,
  output logic [MAC_WIDTH*DATA_SIZE-1:0]      values_in1,
  output logic [MAC_WIDTH*DATA_SIZE-1:0]      values_in2,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0]      values_out1,
  input  logic [MAC_WIDTH*DATA_SIZE-1:0]      values_out2,
  output logic                                res_valid,
  output logic [MAC_WIDTH*DATA_SIZE-1:0]      res_data1,
  output logic [MAC_WIDTH*DATA_SIZE-1:0]      res_data2
`ifdef MAC_CTRL_PERF_EN
  ,
  output logic [31:0]                         perf_cycles,
  output logic [31:0]                         perf_stalls
`endif
);

  localparam int         VW        = MAC_WIDTH * DATA_SIZE;
  localparam int         RW        = row_bits(MAC_WIDTH);
  localparam logic [7:0] LOAD_LAST = 8'(MAC_WIDTH - 1);
  localparam logic [15:0] LAT16    = 16'(LAT);

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   remain_q, remain_d;
  logic [VW-1:0] vin1_q, vin1_d;
  logic [VW-1:0] vin2_q, vin2_d;
  logic          xfer;
  logic          tag_out;

  assign xfer = (state_q == ST_STREAM) && in_valid;

  // Next state; remain_q is a down-counter of transfers left in STREAM
  // and of cycles left in DRAIN.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          remain_d = num_vectors;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          if (remain_q == 16'd0) begin
            state_d  = ST_DRAIN;
            remain_d = LAT16;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (remain_q == 16'd1) begin
            state_d  = ST_DRAIN;
            remain_d = LAT16;
          end else begin
            remain_d = remain_q - 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (remain_q == 16'd1) state_d = ST_DONE;
        else                   remain_d = remain_q - 16'd1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Phase counter toward the matrix: cleared on every state change.
  always_comb begin
    if (state_d != state_q)
      cnt_d = 8'd0;
    else if ((state_q == ST_LOAD) || (state_q == ST_DRAIN) || xfer)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;
  end

  // Operand registers: a transfer lands one cycle later, bubbles drive zero.
  always_comb begin
    vin1_d = xfer ? in_data1 : '0;
    vin2_d = xfer ? in_data2 : '0;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      remain_q <= 16'd0;
      vin1_q   <= '0;
      vin2_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      vin1_q   <= vin1_d;
      vin2_q   <= vin2_d;
    end
  end

  // One tag per transfer; it surfaces when that vector's result is at the
  // bottom edge (one cycle into values_in plus LAT through the array).
  mac_valid_pipe #(
    .DEPTH (LAT + 1)
  ) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (xfer),
    .tag_out (tag_out)
  );

  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_DONE);
  assign w_rd_en            = (state_q == ST_LOAD);
  assign w_rd_row           = (state_q == ST_LOAD) ? cnt_q[RW-1:0] : '0;
  assign instr              = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign in_ready           = (state_q == ST_STREAM);
  assign mac_matrix_counter = cnt_q;
  assign values_in1         = vin1_q;
  assign values_in2         = vin2_q;
  assign res_valid          = tag_out;
  assign res_data1          = tag_out ? values_out1 : '0;
  assign res_data2          = tag_out ? values_out2 : '0;

`ifdef MAC_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating busy-cycle and bubble counters, cleared when a job starts.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if ((state_q == ST_IDLE) && start) begin
      perf_cycles_d = 32'd0;
      perf_stalls_d = 32'd0;
    end else begin
      if (busy && (perf_cycles_q != 32'hFFFF_FFFF))
        perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == ST_STREAM) && !in_valid && (perf_stalls_q != 32'hFFFF_FFFF))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
